// File: rtl/dot_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : dot_matrix_scanner
// Description : Row-scan sequencer for the 8x8 red/green dot matrix with a
//               double-buffered frame store, 8-level PWM brightness and
//               optional per-slot blanking (macro DOT_SCAN_BLANK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module dot_matrix_scanner #(
   parameter int CLK_DIV      = 1000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [63:0] frame_R,
   input  logic [63:0] frame_G,
   input  logic        frame_valid,
   output logic        frame_ready,
   input  logic [2:0]  brightness,
   output logic [7:0]  row_n,
   output logic [7:0]  col_R,
   output logic [7:0]  col_G,
   output logic        frame_done
);

   localparam int c_SLOT_W = $clog2(CLK_DIV);

`ifdef DOT_SCAN_BLANK_EN
   localparam int c_BLANK_LEN = BLANK_CYCLES;
`else
   // Blanking compiled out: every slot starts directly in DRIVE.
   localparam int c_BLANK_LEN = 0 * BLANK_CYCLES;
`endif

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_BLANK = 2'd1;
   localparam logic [1:0] c_DRIVE = 2'd2;

   localparam logic [1:0]          c_SLOT_START = (c_BLANK_LEN == 0) ? c_DRIVE : c_BLANK;
   localparam logic [c_SLOT_W-1:0] c_SLOT_LAST  = c_SLOT_W'(CLK_DIV - 1);
   localparam logic [c_SLOT_W-1:0] c_BLANK_LAST = c_SLOT_W'(c_BLANK_LEN - 1);
   localparam logic [c_SLOT_W-1:0] c_SLOT_ONE   = c_SLOT_W'(1);

   logic [1:0]          r_state;
   logic [2:0]          r_row;
   logic [c_SLOT_W-1:0] r_slot;
   logic [2:0]          r_pwm;
   logic [63:0]         r_act_r;
   logic [63:0]         r_act_g;
   logic [63:0]         r_pend_r;
   logic [63:0]         r_pend_g;
   logic                r_pend_full;
   logic [7:0]          r_row_n;
   logic [7:0]          r_col_r;
   logic [7:0]          r_col_g;
   logic                r_frame_done;

   logic [1:0]          w_nxt_state;
   logic [2:0]          w_nxt_row;
   logic [c_SLOT_W-1:0] w_nxt_slot;
   logic [2:0]          w_nxt_pwm;
   logic                w_boundary;
   logic                w_xfer;
   logic [63:0]         w_act_r_nxt;
   logic [63:0]         w_act_g_nxt;
   logic                w_drive;
   logic                w_lit;
   logic [5:0]          w_idx;
   logic [7:0]          w_byte_r;
   logic [7:0]          w_byte_g;

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_row   = r_row;
      w_nxt_slot  = r_slot;
      w_nxt_pwm   = r_pwm + 3'd1;
      if (!enable) begin
         w_nxt_state = c_IDLE;
         w_nxt_row   = 3'd0;
         w_nxt_slot  = '0;
         w_nxt_pwm   = 3'd0;
      end else if (r_state == c_IDLE) begin
         w_nxt_state = c_SLOT_START;
         w_nxt_row   = 3'd0;
         w_nxt_slot  = '0;
         w_nxt_pwm   = 3'd0;
      end else if (r_slot == c_SLOT_LAST) begin
         w_nxt_state = c_SLOT_START;
         w_nxt_row   = r_row + 3'd1;
         w_nxt_slot  = '0;
      end else begin
         w_nxt_slot = r_slot + c_SLOT_ONE;
         if ((r_state == c_BLANK) && (r_slot == c_BLANK_LAST)) begin
            w_nxt_state = c_DRIVE;
         end
      end
   end

   // Outputs are registered from next-state values so they line up with the
   // state they describe; the buffer swap happens on entry to row 0, slot 0.
   assign w_boundary  = (w_nxt_state != c_IDLE) && (w_nxt_row == 3'd0) && (w_nxt_slot == '0);
   assign w_xfer      = w_boundary && r_pend_full;
   assign w_act_r_nxt = w_xfer ? r_pend_r : r_act_r;
   assign w_act_g_nxt = w_xfer ? r_pend_g : r_act_g;
   assign w_drive     = (w_nxt_state == c_DRIVE);
   assign w_lit       = w_drive && (w_nxt_pwm <= brightness);
   assign w_idx       = {3'd7 - w_nxt_row, 3'b000};
   assign w_byte_r    = w_act_r_nxt[w_idx +: 8];
   assign w_byte_g    = w_act_g_nxt[w_idx +: 8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= c_IDLE;
         r_row        <= 3'd0;
         r_slot       <= '0;
         r_pwm        <= 3'd0;
         r_act_r      <= 64'd0;
         r_act_g      <= 64'd0;
         r_pend_r     <= 64'd0;
         r_pend_g     <= 64'd0;
         r_pend_full  <= 1'b0;
         r_row_n      <= 8'hFF;
         r_col_r      <= 8'h00;
         r_col_g      <= 8'h00;
         r_frame_done <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_row   <= w_nxt_row;
         r_slot  <= w_nxt_slot;
         r_pwm   <= w_nxt_pwm;
         r_act_r <= w_act_r_nxt;
         r_act_g <= w_act_g_nxt;
         if (frame_valid && !r_pend_full) begin
            r_pend_r    <= frame_R;
            r_pend_g    <= frame_G;
            r_pend_full <= 1'b1;
         end else if (w_xfer) begin
            r_pend_full <= 1'b0;
         end
         r_row_n      <= w_drive ? ~(8'h01 << w_nxt_row) : 8'hFF;
         r_col_r      <= w_lit ? w_byte_r : 8'h00;
         r_col_g      <= w_lit ? w_byte_g : 8'h00;
         r_frame_done <= w_drive && (w_nxt_row == 3'd7) && (w_nxt_slot == c_SLOT_LAST);
      end
   end

   assign frame_ready = ~r_pend_full;
   assign row_n       = r_row_n;
   assign col_R       = r_col_r;
   assign col_G       = r_col_g;
   assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_dot_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_dot_matrix_scanner
// Description : Scoreboard bench for dot_matrix_scanner with a frame-time
//               reference model plus directed scan, buffering, PWM and reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_matrix_scanner;

   localparam int CLK_DIV      = 8;
   localparam int BLANK_CYCLES = 2;
`ifdef DOT_SCAN_BLANK_EN
   localparam int BLANK_LEN = BLANK_CYCLES;
`else
   localparam int BLANK_LEN = 0;
`endif

   typedef struct packed {
      logic [7:0] row_n;
      logic [7:0] col_r;
      logic [7:0] col_g;
      logic       done;
      logic       ready;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [63:0] frame_R = 64'd0;
   logic [63:0] frame_G = 64'd0;
   logic        frame_valid = 1'b0;
   logic [2:0]  brightness = 3'd7;
   logic        frame_ready;
   logic [7:0]  row_n;
   logic [7:0]  col_R;
   logic [7:0]  col_G;
   logic        frame_done;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   bit          m_run = 1'b0;
   int          m_t = 0;
   logic [63:0] m_act_r = 64'd0, m_act_g = 64'd0, m_pend_r = 64'd0, m_pend_g = 64'd0;
   bit          m_pend_full = 1'b0;

   always #5 clk = ~clk;

   dot_matrix_scanner #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK_CYCLES)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .frame_R     (frame_R),
      .frame_G     (frame_G),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .brightness  (brightness),
      .row_n       (row_n),
      .col_R       (col_R),
      .col_G       (col_G),
      .frame_done  (frame_done)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Display derived from time since scan start: t cycles in, slot/row/phase fall out by division.
   function automatic exp_t model_out(input logic [2:0] br);
      exp_t e;
      int   slot, row, phase;
      e.row_n = 8'hFF;
      e.col_r = 8'h00;
      e.col_g = 8'h00;
      e.done  = 1'b0;
      e.ready = !m_pend_full;
      if (m_run) begin
         slot  = m_t % CLK_DIV;
         row   = (m_t / CLK_DIV) % 8;
         phase = m_t % 8;
         if (slot >= BLANK_LEN) begin
            e.row_n = ~(8'h01 << row);
            if (phase <= int'(br)) begin
               e.col_r = 8'(m_act_r >> (8 * (7 - row)));
               e.col_g = 8'(m_act_g >> (8 * (7 - row)));
            end
            e.done = (row == 7) && (slot == CLK_DIV - 1);
         end
      end
      return e;
   endfunction

   always @(posedge clk or negedge rst_n) begin : p_model
      bit acc;
      bit xfer;
      if (!rst_n) begin
         m_run = 1'b0;
         m_t = 0;
         m_act_r = 64'd0;
         m_act_g = 64'd0;
         m_pend_r = 64'd0;
         m_pend_g = 64'd0;
         m_pend_full = 1'b0;
         exp_q.delete();
         exp_q.push_back(model_out(3'd0));
      end else begin
         acc = frame_valid && !m_pend_full;
         if (!enable) begin
            m_run = 1'b0;
            m_t = 0;
         end else if (!m_run) begin
            m_run = 1'b1;
            m_t = 0;
         end else begin
            m_t++;
         end
         xfer = m_run && ((m_t % (8 * CLK_DIV)) == 0) && m_pend_full;
         if (xfer) begin
            m_act_r = m_pend_r;
            m_act_g = m_pend_g;
            m_pend_full = 1'b0;
         end
         if (acc) begin
            m_pend_r = frame_R;
            m_pend_g = frame_G;
            m_pend_full = 1'b1;
         end
         exp_q.push_back(model_out(brightness));
      end
   end

   always @(negedge clk) begin : p_monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("sb_row_n", row_n, e.row_n);
         chk("sb_col_R", col_R, e.col_r);
         chk("sb_col_G", col_G, e.col_g);
         chk("sb_frame_done", frame_done, e.done);
         chk("sb_frame_ready", frame_ready, e.ready);
      end
   end

   initial begin
      logic [63:0] a_r;
      logic [63:0] b_r;
      logic [63:0] b_g;
      logic [63:0] c_r;
      logic [63:0] c_g;
      int          done_cnt;
      int          lit3, lit7, exp3, exp7, nz;
      a_r = 64'h0103070810E0C080;
      b_r = 64'hA55A3CC30FF01248;
      b_g = 64'h5AA5C33CF00F8421;
      c_r = 64'hDEADBEEFCAFEF00D;
      c_g = 64'h0123456789ABCDEF;

      repeat (5) @(negedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("idle_row_n", row_n, 8'hFF);
         chk("idle_cols", {col_R, col_G}, 16'h0000);
         chk("idle_ready", frame_ready, 1'b1);
      end

      // Basic scan of frame A, then B accepted mid-frame while C is refused.
      #1;
      frame_R = a_r;
      frame_G = 64'd0;
      frame_valid = 1'b1;
      @(negedge clk);
      chk("accept_ready_drop", frame_ready, 1'b0);
      #1;
      frame_valid = 1'b0;
      enable = 1'b1;
      brightness = 3'd7;
      done_cnt = 0;
      for (int k = 0; k < 128; k++) begin
         @(negedge clk);
         if (frame_done) done_cnt++;
         if (k == 0) chk("slot0_cycle0_row_n", row_n, (BLANK_LEN > 0) ? 8'hFF : 8'hFE);
         if (k == BLANK_LEN) begin
            chk("slot0_drive_row_n", row_n, 8'hFE);
            chk("slot0_drive_col_R", col_R, 8'h01);
         end
         if (k == 7) begin
            chk("slot0_last_row_n", row_n, 8'hFE);
            chk("slot0_last_col_R", col_R, 8'h01);
         end
         if (k == 24 + BLANK_LEN) begin
            chk("slot3_row_n", row_n, 8'hF7);
            chk("slot3_col_R", col_R, 8'h08);
         end
         if (k == 30) chk("pending_ready_low", frame_ready, 1'b0);
         if (k == 62) chk("done_early", frame_done, 1'b0);
         if (k == 63) begin
            chk("done_at_63", frame_done, 1'b1);
            chk("row7_row_n", row_n, 8'h7F);
            chk("row7_col_R", col_R, 8'h80);
            chk("ready_before_boundary", frame_ready, 1'b0);
         end
         if (k == 64 + BLANK_LEN) begin
            chk("frameB_row0_col_R", col_R, b_r[63:56]);
            chk("frameB_row0_col_G", col_G, b_g[63:56]);
         end
         if (k == 70) chk("ready_after_transfer", frame_ready, 1'b1);
         if (k == 127) chk("done_second_frame", frame_done, 1'b1);
         #1;
         if (k == 20) begin
            frame_R = b_r;
            frame_G = b_g;
            frame_valid = 1'b1;
         end
         if (k == 21) frame_valid = 1'b0;
         if (k == 22) begin
            frame_R = c_r;
            frame_G = c_g;
            frame_valid = 1'b1;
         end
         if (k == 40) frame_valid = 1'b0;
      end
      chk("done_pulse_count", done_cnt, 2);

      // Drop enable at slot 5, cycle 4 of the third frame.
      for (int k = 128; k <= 172; k++) begin
         @(negedge clk);
         #1;
         if (k == 172) enable = 1'b0;
      end
      @(negedge clk);
      chk("drop_row_n", row_n, 8'hFF);
      chk("drop_cols", {col_R, col_G}, 16'h0000);
      done_cnt = 0;
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         if (frame_done) done_cnt++;
      end
      chk("drop_no_done", done_cnt, 0);
      #1 enable = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 0) chk("restart_cycle0_row_n", row_n, (BLANK_LEN > 0) ? 8'hFF : 8'hFE);
         if (k == BLANK_LEN) begin
            chk("restart_row0_row_n", row_n, 8'hFE);
            chk("restart_keeps_B", col_R, b_r[63:56]);
         end
      end

      // PWM duty with an all-on frame: brightness 3 for one frame, then 7.
      #1;
      enable = 1'b0;
      frame_R = {64{1'b1}};
      frame_G = 64'd0;
      frame_valid = 1'b1;
      @(negedge clk);
      #1;
      frame_valid = 1'b0;
      enable = 1'b1;
      brightness = 3'd3;
      lit3 = 0;
      lit7 = 0;
      exp3 = 0;
      exp7 = 0;
      for (int k = 0; k < 64; k++) begin
         if ((k % CLK_DIV) >= BLANK_LEN) begin
            exp7++;
            if ((k % 8) <= 3) exp3++;
         end
      end
      for (int k = 0; k < 128; k++) begin
         @(negedge clk);
         if (col_R == 8'hFF) begin
            if (k < 64) lit3++;
            else lit7++;
         end
         #1;
         if (k == 63) brightness = 3'd7;
      end
      chk("pwm_lit_br3", lit3, exp3);
      chk("pwm_lit_br7", lit7, exp7);

      // Randomised traffic against the scoreboard.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         #1;
         frame_valid = ($urandom_range(0, 3) == 0);
         frame_R = {$urandom, $urandom};
         frame_G = {$urandom, $urandom};
         if ($urandom_range(0, 49) == 0) brightness = 3'($urandom_range(0, 7));
         enable = ($urandom_range(0, 199) != 0);
      end

      // Asynchronous reset mid-scan with a frame pending.
      @(negedge clk);
      #1;
      enable = 1'b1;
      frame_valid = 1'b1;
      frame_R = c_r;
      frame_G = c_g;
      @(negedge clk);
      #1 frame_valid = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_row_n", row_n, 8'hFF);
      chk("async_rst_cols", {col_R, col_G}, 16'h0000);
      chk("async_rst_ready", frame_ready, 1'b1);
      chk("async_rst_done", frame_done, 1'b0);
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;
      brightness = 3'd7;
      nz = 0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if ((col_R != 8'h00) || (col_G != 8'h00)) nz++;
      end
      chk("post_reset_buffers_clear", nz, 0);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dot_matrix_scanner.md
# dot_matrix_scanner

Row-scan sequencer for the 8×8 red/green fan-status dot matrix. It accepts 64-bit R/G frames from the pattern generator through a valid/ready handshake and double-buffers them so a frame never changes mid-scan. It time-multiplexes the frame onto the physical row-select and column lines, with optional inter-row blanking and 8-level PWM brightness. It sits between the pattern generator and the board pins.

## Interface
- CLK_DIV, 1000: clocks per row slot; legal range ≥ 4.
- BLANK_CYCLES, 16: blanking clocks at the start of each slot; must be < CLK_DIV. Used only when blanking is compiled in.
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  scan enable; low forces all LEDs off.
- frame_R  in  64  red frame; row r = bits [63-8r : 56-8r]; bit 7 of each byte is the leftmost column.
- frame_G  in  64  green frame; same mapping as frame_R.
- frame_valid  in  1  a new frame is presented.
- frame_ready  out  1  pending buffer empty; the frame is accepted when valid && ready.
- brightness  in  3  PWM level; 7 = full on, 0 = 1/8 duty.
- row_n  out  8  row select, active-low, one-hot-low; row_n[r] drives row r.
- col_R  out  8  red column drive, active-high; col_R[7] is leftmost.
- col_G  out  8  green column drive, active-high.
- frame_done  out  1  one-cycle pulse at the end of the row-7 slot.

## Operation
- Storage: an active buffer (R+G, 128 b) feeds the scan. A pending buffer (128 b) holds the accepted frame, plus a pend_full flag.
- frame_ready = !pend_full.
- On accept: the pending buffer takes frame_R/G and pend_full goes to 1.
- Frame boundary is the first cycle of the row-0 slot. If pend_full, the active buffer loads from pending and pend_full clears.
- A frame accepted on the boundary cycle itself does not transfer; it is displayed from the next boundary.
- State machine:
  - IDLE → BLANK on enable=1. Without blanking compiled in, IDLE → DRIVE instead.
  - BLANK → DRIVE after BLANK_CYCLES clocks.
  - DRIVE → BLANK at the end of the slot; the row advances, 7 wraps to 0.
  - Any state → IDLE when enable=0.
- Counters: slot_cnt runs 0..CLK_DIV-1; row runs 0..7.
- pwm_phase is a 3-bit free-running counter while enabled; it clears in IDLE.
- BLANK: row_n=8'hFF, col_R=col_G=0.
- DRIVE:
  - row_n = ~(8'h01 << row).
  - col_R/col_G = the active row byte when pwm_phase ≤ brightness, else 0.
  - With brightness=7, columns are never gated.
- IDLE: row_n=8'hFF, columns 0, row=0, slot_cnt=0. The handshake and pending buffer remain operational.
- frame_done is asserted on the last cycle (slot_cnt=CLK_DIV-1) of the row-7 slot, in DRIVE.

## Timing
- Reset values:
  - row_n=8'hFF, col_R=col_G=8'h00, frame_done=0, frame_ready=1.
  - Both buffers zero, pend_full=0.
  - State IDLE, row=0, slot_cnt=0, pwm_phase=0.
- All outputs are registered and change only on clk rising edges.
- The first rising edge with enable=1 in IDLE starts slot_cnt=0 of row 0; this is a frame boundary.
- Each slot is exactly CLK_DIV cycles.
  - Row r is asserted for slot cycles BLANK_CYCLES..CLK_DIV-1.
  - Without blanking, row r is asserted for cycles 0..CLK_DIV-1.
- A full frame is 8×CLK_DIV cycles. frame_done pulses once per frame, with period 8×CLK_DIV.
- Handshake: frame_ready drops the cycle after acceptance. It rises the cycle after the boundary transfer.
- The input frame may change freely while frame_ready=0.
- Dropping enable mid-slot:
  - The next edge gives IDLE outputs; no frame_done is issued.
  - The active buffer is retained; pend_full is retained.
- Reset mid-scan: all state returns to reset values asynchronously, including any pending frame.
- brightness is sampled every cycle; a change takes effect on the next edge.

## Configuration
- DOT_SCAN_BLANK_EN defined: BLANK state present; each slot begins with BLANK_CYCLES dark cycles for anti-ghosting.
- DOT_SCAN_BLANK_EN undefined: no BLANK state; BLANK_CYCLES is ignored; a row is driven for all CLK_DIV cycles of its slot.

## Test plan
All scenarios use CLK_DIV=8 and BLANK_CYCLES=2 with DOT_SCAN_BLANK_EN defined, unless stated otherwise.
- Reset/idle: hold rst_n=0, then release with enable=0. Required: row_n=FF, cols=00, frame_ready=1 for 50 cycles.
- Basic scan:
  - Stimulus: accept R=64'h0103070810E0C080, G=0, enable=1, brightness=7.
  - Slot 0: row_n=FF for 2 cycles, then FE with col_R=01 for 6 cycles.
  - Slot 3: row_n=F7, col_R=08.
  - frame_done pulses at cycle 63 of the frame.
- Double buffering:
  - Stimulus: accept frame B mid-scan while frame A is displayed.
  - Required: frame_ready=0 until the boundary; rows keep showing A until row 0 of the next frame, then show B.
  - A second valid offered while ready=0 is not taken.
- PWM: brightness=1 with row byte 8'hFF. Required: col_R=FF only on pwm_phase 0–1, i.e. 2 of every 8 DRIVE cycles.
- Enable drop: deassert enable at slot 5, cycle 4. Required: next edge gives row_n=FF; re-enable restarts at row 0 and cycle 0; no frame_done in between.
- Macro off (DOT_SCAN_BLANK_EN undefined): required row_n=FE for all 8 cycles of slot 0, never FF between rows.
